// File: rtl/sram_1r1w_mask_ext_if.sv
// Request/response bundle for the 1R1W masked SRAM: read port R0 and write port W0.
// The master drives requests; the slave (memory) returns registered read data.
interface sram_1r1w_mask_ext_if #(
    parameter int ADDR_W = 7,
    parameter int WIDTH  = 192,
    parameter int MASK_W = 8
);
    logic              R0_en;
    logic [ADDR_W-1:0] R0_addr;
    logic [WIDTH-1:0]  R0_data;
    logic              R0_valid;
    logic              W0_en;
    logic [ADDR_W-1:0] W0_addr;
    logic [MASK_W-1:0] W0_mask;
    logic [WIDTH-1:0]  W0_data;

    modport master (
        output R0_en, R0_addr, W0_en, W0_addr, W0_mask, W0_data,
        input  R0_data, R0_valid
    );

    modport slave (
        input  R0_en, R0_addr, W0_en, W0_addr, W0_mask, W0_data,
        output R0_data, R0_valid
    );
endinterface

// File: rtl/sram_1r1w_mask_ext.sv
// Behavioural 1R1W SRAM with lane write masks, optional write-to-read bypass,
// a read-data hold register and a zeroing sweep after reset.
module sram_1r1w_mask_ext #(
    parameter int DEPTH      = 128,
    parameter int WIDTH      = 192,
    parameter int MASK_GRAN  = 24,
    parameter int BYPASS     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sram_1r1w_mask_ext_if.slave   bus,
    output logic                  init_busy
);
    localparam int ADDR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int MASK_W = WIDTH / MASK_GRAN;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
        $fatal(1, "sram_1r1w_mask_ext: WIDTH must be a multiple of MASK_GRAN");
    end
    if ($bits(bus.R0_data) != WIDTH || $bits(bus.W0_mask) != MASK_W ||
        $bits(bus.R0_addr) != ADDR_W) begin : g_bad_if
        $fatal(1, "sram_1r1w_mask_ext: interface widths do not match parameters");
    end

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_s;
    logic              init_busy_r;
    logic              init_busy_s;
    logic [WIDTH-1:0]  rd_data_r;
    logic              rd_valid_r;

    logic              clear_we_s;
    logic              rd_in_range_s;
    logic              wr_in_range_s;
    logic              rd_fire_s;
    logic              wr_fire_s;
    logic              collide_s;
    logic [WIDTH-1:0]  rd_old_s;
    logic [WIDTH-1:0]  rd_merge_s;

    logic [WIDTH-1:0]  mem_r [DEPTH];

    // Sweep sequencing: CLEAR walks cnt through every entry once, then READY forever.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        clear_we_s  = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                clear_we_s = reset_n;
                if (cnt_r == LAST_ADDR) begin
                    state_s = ST_READY;
                    cnt_s   = {ADDR_W{1'b0}};
                end else begin
                    state_s = ST_CLEAR;
                    cnt_s   = cnt_r + ADDR_W'(1);
                end
            end
            ST_READY: begin
                state_s = ST_READY;
                cnt_s   = cnt_r;
            end
            default: begin
                state_s = ST_CLEAR;
                cnt_s   = {ADDR_W{1'b0}};
            end
        endcase
        init_busy_s = (state_s == ST_CLEAR);
    end

    // Request qualification and same-address bypass merge of the read word.
    always_comb begin
        rd_in_range_s = ({1'b0, bus.R0_addr} < DEPTH_X);
        wr_in_range_s = ({1'b0, bus.W0_addr} < DEPTH_X);
        rd_fire_s     = (state_r == ST_READY) && bus.R0_en;
        wr_fire_s     = (state_r == ST_READY) && bus.W0_en && wr_in_range_s && reset_n;
        collide_s     = (BYPASS != 0) && rd_fire_s && wr_fire_s &&
                        (bus.R0_addr == bus.W0_addr);
        if (rd_in_range_s) begin
            rd_old_s = mem_r[bus.R0_addr];
        end else begin
            rd_old_s = {WIDTH{1'b0}};
        end
        rd_merge_s = rd_old_s;
        for (int i = 0; i < MASK_W; i++) begin
            if (collide_s && bus.W0_mask[i]) begin
                rd_merge_s[i*MASK_GRAN +: MASK_GRAN] = bus.W0_data[i*MASK_GRAN +: MASK_GRAN];
            end else begin
                rd_merge_s[i*MASK_GRAN +: MASK_GRAN] = rd_old_s[i*MASK_GRAN +: MASK_GRAN];
            end
        end
    end

    // Control state, sweep counter and busy flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            cnt_r       <= {ADDR_W{1'b0}};
            init_busy_r <= (INIT_CLEAR != 0);
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            init_busy_r <= init_busy_s;
        end
    end

    // Read data register holds its value whenever no read is issued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_r  <= {WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (state_r == ST_READY) begin
            rd_valid_r <= bus.R0_en;
            if (rd_fire_s) begin
                rd_data_r <= rd_merge_s;
            end
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    // Storage array: no reset; cleared only by the sweep, written lane by lane.
    always_ff @(posedge clock) begin
        if (clear_we_s) begin
            mem_r[cnt_r] <= {WIDTH{1'b0}};
        end else if (wr_fire_s) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (bus.W0_mask[i]) begin
                    mem_r[bus.W0_addr][i*MASK_GRAN +: MASK_GRAN] <=
                        bus.W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    assign bus.R0_data  = rd_data_r;
    assign bus.R0_valid = rd_valid_r;
    assign init_busy    = init_busy_r;
endmodule

// File: tb/tb_sram_1r1w_mask_ext.sv
// Directed bench for sram_1r1w_mask_ext: three builds (BYPASS=1, BYPASS=0, DEPTH=100)
// driven by one shared stimulus set.
module tb_sram_1r1w_mask_ext;
    logic         clk;
    logic         rst_n;
    logic         r_en;
    logic [6:0]   r_addr;
    logic         w_en;
    logic [6:0]   w_addr;
    logic [7:0]   w_mask;
    logic [191:0] w_data;
    logic         busy_a;
    logic         busy_b;
    logic         busy_c;

    int tests;
    int fails;

    sram_1r1w_mask_ext_if #(.ADDR_W(7), .WIDTH(192), .MASK_W(8)) if_a ();
    sram_1r1w_mask_ext_if #(.ADDR_W(7), .WIDTH(192), .MASK_W(8)) if_b ();
    sram_1r1w_mask_ext_if #(.ADDR_W(7), .WIDTH(192), .MASK_W(8)) if_c ();

    assign if_a.R0_en = r_en;   assign if_b.R0_en = r_en;   assign if_c.R0_en = r_en;
    assign if_a.R0_addr = r_addr; assign if_b.R0_addr = r_addr; assign if_c.R0_addr = r_addr;
    assign if_a.W0_en = w_en;   assign if_b.W0_en = w_en;   assign if_c.W0_en = w_en;
    assign if_a.W0_addr = w_addr; assign if_b.W0_addr = w_addr; assign if_c.W0_addr = w_addr;
    assign if_a.W0_mask = w_mask; assign if_b.W0_mask = w_mask; assign if_c.W0_mask = w_mask;
    assign if_a.W0_data = w_data; assign if_b.W0_data = w_data; assign if_c.W0_data = w_data;

    sram_1r1w_mask_ext #(.DEPTH(128), .WIDTH(192), .MASK_GRAN(24), .BYPASS(1), .INIT_CLEAR(1))
        dut_a (.clock(clk), .reset_n(rst_n), .bus(if_a.slave), .init_busy(busy_a));
    sram_1r1w_mask_ext #(.DEPTH(128), .WIDTH(192), .MASK_GRAN(24), .BYPASS(0), .INIT_CLEAR(1))
        dut_b (.clock(clk), .reset_n(rst_n), .bus(if_b.slave), .init_busy(busy_b));
    sram_1r1w_mask_ext #(.DEPTH(100), .WIDTH(192), .MASK_GRAN(24), .BYPASS(1), .INIT_CLEAR(1))
        dut_c (.clock(clk), .reset_n(rst_n), .bus(if_c.slave), .init_busy(busy_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r_en   = 1'b0;
        r_addr = 7'd0;
        w_en   = 1'b0;
        w_addr = 7'd0;
        w_mask = 8'h00;
        w_data = 192'd0;
    endtask

    // Runs until both sweeps end (bounded), optionally issuing requests early on.
    task automatic wait_sweep(input bit with_req, output int na, output int nc, output bit saw_valid);
        na = 0;
        nc = 0;
        saw_valid = 1'b0;
        for (int k = 0; k < 300 && (busy_a || busy_c); k++) begin
            if (with_req && k < 50) begin
                r_en = 1'b1; r_addr = 7'd5;
                w_en = 1'b1; w_addr = 7'd5; w_mask = 8'hFF; w_data = '1;
            end else begin
                idle();
            end
            if (busy_a) na++;
            if (busy_c) nc++;
            cyc();
            if (if_a.R0_valid || if_b.R0_valid || if_c.R0_valid) saw_valid = 1'b1;
        end
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        cyc();
        cyc();
        tests++; if (if_a.R0_data !== 192'd0) begin fails++; $display("FAIL reset_data got=%h exp=0", if_a.R0_data); end
        tests++; if (if_a.R0_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", if_a.R0_valid); end
        tests++; if ({busy_a, busy_b, busy_c} !== 3'b111) begin fails++; $display("FAIL reset_busy got=%b exp=111", {busy_a, busy_b, busy_c}); end
    endtask

    task automatic test_sweep();
        int na, nc;
        bit sv;
        rst_n = 1'b1;
        wait_sweep(1'b1, na, nc, sv);
        tests++; if (na != 128) begin fails++; $display("FAIL sweep_len_128 got=%0d exp=128", na); end
        tests++; if (nc != 100) begin fails++; $display("FAIL sweep_len_100 got=%0d exp=100", nc); end
        tests++; if (sv !== 1'b0) begin fails++; $display("FAIL sweep_valid got=%b exp=0", sv); end
        tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL sweep_busy_b got=%b exp=0", busy_b); end
        r_en = 1'b1; r_addr = 7'd5;
        cyc();
        idle();
        tests++; if (if_a.R0_data !== 192'd0 || if_a.R0_valid !== 1'b1) begin fails++; $display("FAIL first_read_a got=%h v=%b exp=0 v=1", if_a.R0_data, if_a.R0_valid); end
        tests++; if (if_b.R0_data !== 192'd0) begin fails++; $display("FAIL first_read_b got=%h exp=0", if_b.R0_data); end
        tests++; if (if_c.R0_data !== 192'd0) begin fails++; $display("FAIL first_read_c got=%h exp=0", if_c.R0_data); end
    endtask

    task automatic test_out_of_range();
        w_en = 1'b1; w_addr = 7'd120; w_mask = 8'hFF; w_data = '1;
        cyc();
        idle();
        for (int i = 0; i < 100; i++) begin
            r_en = 1'b1; r_addr = 7'(i);
            cyc();
            tests++; if (if_c.R0_data !== 192'd0) begin fails++; $display("FAIL oor_scan addr=%0d got=%h exp=0", i, if_c.R0_data); end
        end
        idle();
        w_en = 1'b1; w_addr = 7'd50; w_mask = 8'hFF; w_data = '1;
        cyc();
        idle();
        r_en = 1'b1; r_addr = 7'd50;
        cyc();
        tests++; if (if_c.R0_data !== {192{1'b1}}) begin fails++; $display("FAIL oor_inrange got=%h exp=all-ones", if_c.R0_data); end
        r_addr = 7'd110;
        cyc();
        idle();
        tests++; if (if_c.R0_data !== 192'd0 || if_c.R0_valid !== 1'b1) begin fails++; $display("FAIL oor_read got=%h v=%b exp=0 v=1", if_c.R0_data, if_c.R0_valid); end
    endtask

    task automatic test_masked_write();
        logic [191:0] exp_v;
        exp_v = {{6{24'hA5A5A5}}, 24'h123456, 24'hA5A5A5};
        w_en = 1'b1; w_addr = 7'd5; w_mask = 8'hFF; w_data = {8{24'hA5A5A5}};
        cyc();
        w_mask = 8'h02; w_data = {{6{24'hFFFFFF}}, 24'h123456, 24'hFFFFFF};
        cyc();
        idle();
        r_en = 1'b1; r_addr = 7'd5;
        cyc();
        r_en = 1'b0;
        tests++; if (if_a.R0_data !== exp_v || if_a.R0_valid !== 1'b1) begin fails++; $display("FAIL masked_a got=%h v=%b exp=%h v=1", if_a.R0_data, if_a.R0_valid, exp_v); end
        tests++; if (if_c.R0_data !== exp_v) begin fails++; $display("FAIL masked_c got=%h exp=%h", if_c.R0_data, exp_v); end
        cyc();
        tests++; if (if_a.R0_valid !== 1'b0) begin fails++; $display("FAIL masked_valid_drop got=%b exp=0", if_a.R0_valid); end
        idle();
    endtask

    task automatic test_collision();
        logic [191:0] old_v;
        logic [191:0] mrg_v;
        old_v = {8{24'h111111}};
        mrg_v = {24'hFFFFFF, {6{24'h111111}}, 24'hFFFFFF};
        w_en = 1'b1; w_addr = 7'd9; w_mask = 8'hFF; w_data = old_v;
        cyc();
        r_en = 1'b1; r_addr = 7'd9;
        w_mask = 8'h81; w_data = '1;
        cyc();
        tests++; if (if_a.R0_data !== mrg_v) begin fails++; $display("FAIL collide_bypass got=%h exp=%h", if_a.R0_data, mrg_v); end
        tests++; if (if_b.R0_data !== old_v) begin fails++; $display("FAIL collide_nobypass got=%h exp=%h", if_b.R0_data, old_v); end
        w_en = 1'b0;
        cyc();
        idle();
        tests++; if (if_a.R0_data !== mrg_v) begin fails++; $display("FAIL collide_next_a got=%h exp=%h", if_a.R0_data, mrg_v); end
        tests++; if (if_b.R0_data !== mrg_v) begin fails++; $display("FAIL collide_next_b got=%h exp=%h", if_b.R0_data, mrg_v); end
    endtask

    task automatic test_hold();
        logic [191:0] x_v;
        x_v = {8{24'h3C3C3C}};
        w_en = 1'b1; w_addr = 7'd3; w_mask = 8'hFF; w_data = x_v;
        cyc();
        idle();
        r_en = 1'b1; r_addr = 7'd3;
        cyc();
        tests++; if (if_a.R0_data !== x_v) begin fails++; $display("FAIL hold_first got=%h exp=%h", if_a.R0_data, x_v); end
        r_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            w_en = 1'b1; w_addr = 7'd3; w_mask = 8'hFF; w_data = {8{24'hC3C3C3}};
            cyc();
            tests++; if (if_a.R0_data !== x_v || if_a.R0_valid !== 1'b0) begin fails++; $display("FAIL hold_cycle%0d got=%h v=%b exp=%h v=0", k, if_a.R0_data, if_a.R0_valid, x_v); end
        end
        idle();
    endtask

    task automatic test_reset_mid_sweep();
        int na, nc;
        bit sv;
        r_en = 1'b1; r_addr = 7'd3;
        cyc();
        idle();
        tests++; if (if_a.R0_data !== {8{24'hC3C3C3}}) begin fails++; $display("FAIL pre_reset_read got=%h exp=c3..", if_a.R0_data); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (if_a.R0_data !== 192'd0 || if_a.R0_valid !== 1'b0 || busy_a !== 1'b1) begin fails++; $display("FAIL async_reset got=%h v=%b b=%b exp=0 v=0 b=1", if_a.R0_data, if_a.R0_valid, busy_a); end
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r_en = 1'b1; r_addr = 7'd3;
            w_en = 1'b1; w_addr = 7'd0; w_mask = 8'hFF; w_data = '1;
            cyc();
        end
        idle();
        #2 rst_n = 1'b0;
        #1;
        tests++; if (if_a.R0_data !== 192'd0 || if_a.R0_valid !== 1'b0 || busy_a !== 1'b1) begin fails++; $display("FAIL mid_sweep_reset got=%h v=%b b=%b exp=0 v=0 b=1", if_a.R0_data, if_a.R0_valid, busy_a); end
        cyc();
        rst_n = 1'b1;
        wait_sweep(1'b1, na, nc, sv);
        tests++; if (na != 128) begin fails++; $display("FAIL resweep_len_128 got=%0d exp=128", na); end
        tests++; if (nc != 100) begin fails++; $display("FAIL resweep_len_100 got=%0d exp=100", nc); end
        tests++; if (sv !== 1'b0) begin fails++; $display("FAIL resweep_valid got=%b exp=0", sv); end
        for (int i = 0; i < 128; i++) begin
            r_en = 1'b1; r_addr = 7'(i);
            cyc();
            tests++; if (if_a.R0_data !== 192'd0 || if_c.R0_data !== 192'd0 || if_a.R0_valid !== 1'b1) begin fails++; $display("FAIL resweep_scan addr=%0d a=%h c=%h v=%b exp=0 v=1", i, if_a.R0_data, if_c.R0_data, if_a.R0_valid); end
        end
        idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_sweep();
        test_out_of_range();
        test_masked_write();
        test_collision();
        test_hold();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
